// File: rtl/bcd_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner_pkg
// Shared constants for the multiplexed seven-segment display scanner:
//   - scan FSM state encoding (s_BLANK / s_ON)
//   - active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - small elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package bcd_display_scanner_pkg;

    // Scan FSM: each digit slot is a dark gap followed by the lit period.
    typedef enum logic {
        s_BLANK = 1'b0,
        s_ON    = 1'b1
    } scan_state_t;

    // Active-high segment patterns, {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    // Non-decimal codes (10-15) render as a dash: segment g only.
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Larger of two integers, used to size the shared slot counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_decode.sv
// -----------------------------------------------------------------------------
// seven_seg_decode
// Purely combinational BCD-to-seven-segment decoder.
//   code     : 4-bit digit code; 0-9 decode normally, 10-15 show a dash
//   segments : active-high segments {g,f,e,d,c,b,a}
// Output polarity for the board is applied by the caller.
// -----------------------------------------------------------------------------
module seven_seg_decode
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_DASH;
        case (code)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
// Time-multiplexed driver for DIGITS seven-segment digits. Each digit gets a
// slot made of BLANK_CYCLES clocks with everything dark (suppresses ghosting
// while anodes switch) followed by ON_CYCLES clocks with only that digit lit.
//
// Parameters
//   DIGITS       number of digits scanned
//   ON_CYCLES    lit clocks per digit slot
//   BLANK_CYCLES dark clocks between slots
//   ACTIVE_LOW   1 = segment, DP and anode outputs are active-low
//
// Ports
//   i_Clock          system clock, rising edge
//   i_Reset          synchronous active-high reset
//   i_BCD            packed BCD value, digit 0 (rightmost) in [3:0]
//   i_DV             one-cycle strobe qualifying i_BCD / i_DP
//   i_Blank_Leading  1 = leading zeros are dark (sampled live)
//   i_DP             per-digit decimal-point enables
//   o_Segments       {g,f,e,d,c,b,a}, registered
//   o_DP             decimal-point segment, registered
//   o_Anode          digit enables, registered, at most one active
//   o_Frame          one-cycle pulse following the wrap from the last digit
//
// New values land in a shadow register and only move to the display register
// at the frame wrap, so a single frame never mixes old and new digits.
// -----------------------------------------------------------------------------
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [DIGITS*4-1:0]   i_BCD,
    input  logic                  i_DV,
    input  logic                  i_Blank_Leading,
    input  logic [DIGITS-1:0]     i_DP,
    output logic [6:0]            o_Segments,
    output logic                  o_DP,
    output logic [DIGITS-1:0]     o_Anode,
    output logic                  o_Frame
);

    // -------------------------------------------------------------------------
    // Sizing and polarity constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = $clog2(max_int(ON_CYCLES, BLANK_CYCLES) + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    // XOR masks that convert active-high internal values to board polarity.
    // Applied to an all-zero value they also give the "inactive" level.
    localparam bit                INV        = (ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_POL    = {7{INV}};
    localparam logic [DIGITS-1:0] ANODE_POL  = {DIGITS{INV}};
    localparam logic              DP_POL     = INV;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    scan_state_t              state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [IDX_W-1:0]         idx_reg;

    logic [DIGITS*4-1:0]      shadow_bcd_reg;
    logic [DIGITS-1:0]        shadow_dp_reg;
    logic [DIGITS*4-1:0]      disp_bcd_reg;
    logic [DIGITS-1:0]        disp_dp_reg;

    logic [6:0]               seg_reg;
    logic                     dp_reg;
    logic [DIGITS-1:0]        anode_reg;
    logic                     frame_reg;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                     slot_done;
    logic                     wrap;
    logic [3:0]               digit_code [DIGITS];
    logic [DIGITS-1:0]        dark_vec;
    logic [DIGITS-1:0]        anode_onehot;
    logic [3:0]               sel_code;
    logic [6:0]               sel_seg;
    logic                     sel_dark;
    logic                     sel_dp;

    assign slot_done = (state_reg == s_BLANK) ? (cnt_reg == BLANK_LAST)
                                              : (cnt_reg == ON_LAST);

    // Last clock of the last digit's lit period: the scan returns to digit 0.
    assign wrap = (state_reg == s_ON) && (cnt_reg == ON_LAST) && (idx_reg == IDX_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_code[gi]   = disp_bcd_reg[gi*4 +: 4];
            assign anode_onehot[gi] = (idx_reg == IDX_W'(gi));

            // A digit is dark when it and every more-significant digit are
            // zero. Digit 0 always shows, so a value of zero reads "0".
            if (gi == 0) begin : g_lsd
                assign dark_vec[gi] = 1'b0;
            end else begin : g_upper
                assign dark_vec[gi] = i_Blank_Leading &&
                                      (disp_bcd_reg[DIGITS*4-1:gi*4] == '0);
            end
        end
    endgenerate

    assign sel_code = digit_code[idx_reg];
    assign sel_dark = dark_vec[idx_reg];
    assign sel_dp   = disp_dp_reg[idx_reg];

    seven_seg_decode u_decode (
        .code     (sel_code),
        .segments (sel_seg)
    );

    // -------------------------------------------------------------------------
    // Scan FSM, value registers and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg      <= s_BLANK;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shadow_bcd_reg <= '0;
            shadow_dp_reg  <= '0;
            disp_bcd_reg   <= '0;
            disp_dp_reg    <= '0;
            seg_reg        <= SEG_POL;
            dp_reg         <= DP_POL;
            anode_reg      <= ANODE_POL;
            frame_reg      <= 1'b0;
        end else begin
            // Outputs follow the current state/index one clock later.
            frame_reg <= wrap;
            if (state_reg == s_ON) begin
                anode_reg <= anode_onehot ^ ANODE_POL;
                seg_reg   <= (sel_dark ? SEG_OFF : sel_seg) ^ SEG_POL;
                // DP is independent of leading blanking.
                dp_reg    <= sel_dp ^ DP_POL;
            end else begin
                anode_reg <= ANODE_POL;
                seg_reg   <= SEG_POL;
                dp_reg    <= DP_POL;
            end

            case (state_reg)
                s_BLANK: begin
                    if (slot_done) begin
                        state_reg <= s_ON;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                s_ON: begin
                    if (slot_done) begin
                        state_reg <= s_BLANK;
                        cnt_reg   <= '0;
                        idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= s_BLANK;
                    cnt_reg   <= '0;
                end
            endcase

            // Latest strobe wins in the shadow.
            if (i_DV) begin
                shadow_bcd_reg <= i_BCD;
                shadow_dp_reg  <= i_DP;
            end

            // A strobe coincident with the wrap bypasses the shadow so it is
            // not delayed by a whole extra frame.
            if (wrap) begin
                disp_bcd_reg <= i_DV ? i_BCD : shadow_bcd_reg;
                disp_dp_reg  <= i_DV ? i_DP  : shadow_dp_reg;
            end
        end
    end

    assign o_Segments = seg_reg;
    assign o_DP       = dp_reg;
    assign o_Anode    = anode_reg;
    assign o_Frame    = frame_reg;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scanner
// Self-checking bench for bcd_display_scanner with DIGITS=4, ON_CYCLES=4,
// BLANK_CYCLES=2, ACTIVE_LOW=1. A reference model derives the expected
// outputs from the position inside the 24-clock scan period; directed steps
// exercise the called-out scenarios, then a random phase runs.
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

    localparam int DIGITS = 4;
    localparam int ON     = 4;
    localparam int BLANK  = 2;
    localparam int SLOT   = ON + BLANK;
    localparam int PERIOD = SLOT * DIGITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv  = 1'b0;
    logic        bl  = 1'b0;
    logic [15:0] bcd = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0]  o_Segments;
    logic        o_DP;
    logic [3:0]  o_Anode;
    logic        o_Frame;

    bcd_display_scanner #(
        .DIGITS       (DIGITS),
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BLANK),
        .ACTIVE_LOW   (1)
    ) dut (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_BCD           (bcd),
        .i_DV            (dv),
        .i_Blank_Leading (bl),
        .i_DP            (dp_in),
        .o_Segments      (o_Segments),
        .o_DP            (o_DP),
        .o_Anode         (o_Anode),
        .o_Frame         (o_Frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: mt = clocks since reset release (scan time).
    int          mt = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_shadow_dp = '0;
    logic [3:0]  m_disp_dp = '0;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [3:0]  e_anode = 4'hF;
    logic        e_frame = 1'b0;

    // Active-high reference glyphs {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge, then
    // compare every output on the falling edge.
    task automatic tick();
        int pos;
        int dig;
        bit on;
        bit dark;
        @(posedge clk);
        if (rst) begin
            e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
            m_shadow = '0; m_disp = '0; m_shadow_dp = '0; m_disp_dp = '0;
            mt = 0;
        end else begin
            pos = mt % PERIOD;
            dig = pos / SLOT;
            on  = (pos % SLOT) >= BLANK;
            e_frame = (pos == PERIOD - 1);
            if (on) begin
                e_anode = ~(4'b0001 << dig);
                dark    = bl && (dig != 0) && ((m_disp >> (dig * 4)) == 16'd0);
                e_seg   = dark ? 7'h7F : ~glyph(m_disp[dig*4 +: 4]);
                e_dp    = ~m_disp_dp[dig];
            end else begin
                e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            if (pos == PERIOD - 1) begin
                m_disp    = dv ? bcd   : m_shadow;
                m_disp_dp = dv ? dp_in : m_shadow_dp;
            end
            if (dv) begin
                m_shadow    = bcd;
                m_shadow_dp = dp_in;
            end
            mt++;
        end
        @(negedge clk);
        check("anode", 32'(o_Anode), 32'(e_anode));
        check("segments", 32'(o_Segments), 32'(e_seg));
        check("dp", 32'(o_DP), 32'(e_dp));
        check("frame", 32'(o_Frame), 32'(e_frame));
        $display("t=%0t scan=%0d anode=%b seg=%h dp=%b frame=%b", $time, mt, o_Anode, o_Segments, o_DP, o_Frame);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_until_anode(input logic [3:0] target, input int limit);
        int k;
        k = 0;
        while (o_Anode !== target && k < limit) begin
            tick();
            k++;
        end
        check("anode_reached", 32'(o_Anode), 32'(target));
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] d);
        bcd = v; dp_in = d; dv = 1'b1;
        tick();
        dv = 1'b0;
    endtask

    logic [3:0] seq_exp [9];

    initial begin
        seq_exp = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};

        // Reset state
        rst = 1'b1;
        run(3);
        check("rst_anode", 32'(o_Anode), 32'h0000000F);
        check("rst_seg", 32'(o_Segments), 32'h0000007F);
        check("rst_dp", 32'(o_DP), 32'h1);
        check("rst_frame", 32'(o_Frame), 32'h0);

        // Scan sequence after release, frame pulse every PERIOD clocks
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("scan_seq", 32'(o_Anode), 32'(seq_exp[i]));
        end
        run(PERIOD - 10);
        check("frame_low", 32'(o_Frame), 32'h0);
        tick();
        check("frame_pulse1", 32'(o_Frame), 32'h1);
        run(PERIOD - 1);
        tick();
        check("frame_pulse2", 32'(o_Frame), 32'h1);

        // Mid-frame update: old value stays until the wrap
        run(8);
        send(16'h1234, 4'b0000);
        run_until_anode(4'b1011, 40);
        check("old_digit2", 32'(o_Segments), 32'h40);
        run_until_anode(4'b1110, 40);
        check("new_digit0", 32'(o_Segments), 32'h19);
        run_until_anode(4'b1101, 40);
        check("new_digit1", 32'(o_Segments), 32'h30);
        run_until_anode(4'b1011, 40);
        check("new_digit2", 32'(o_Segments), 32'h24);
        run_until_anode(4'b0111, 40);
        check("new_digit3", 32'(o_Segments), 32'h79);

        // Leading-zero blanking, DP on a blanked digit, live blank control
        bl = 1'b1;
        send(16'h0007, 4'b0100);
        run(PERIOD);
        run_until_anode(4'b1110, 40);
        check("lz_digit0", 32'(o_Segments), 32'h78);
        run_until_anode(4'b1101, 40);
        check("lz_digit1", 32'(o_Segments), 32'h7F);
        run_until_anode(4'b1011, 40);
        check("lz_digit2", 32'(o_Segments), 32'h7F);
        check("lz_digit2_dp", 32'(o_DP), 32'h0);
        run_until_anode(4'b0111, 40);
        check("lz_digit3", 32'(o_Segments), 32'h7F);
        bl = 1'b0;
        run_until_anode(4'b1101, 40);
        check("nolz_digit1", 32'(o_Segments), 32'h40);

        // Non-decimal code shows a dash
        send(16'h00A0, 4'b0000);
        run(PERIOD);
        run_until_anode(4'b1101, 40);
        check("dash_digit1", 32'(o_Segments), 32'h3F);
        run_until_anode(4'b1110, 40);
        check("dash_digit0", 32'(o_Segments), 32'h40);

        // Strobe coincident with the wrap cycle
        begin
            int k;
            k = 0;
            while ((mt % PERIOD) != PERIOD - 1 && k < 2 * PERIOD) begin
                tick();
                k++;
            end
            check("reach_wrap", 32'(mt % PERIOD), 32'(PERIOD - 1));
        end
        send(16'h5678, 4'b0001);
        run_until_anode(4'b1110, 20);
        check("wrapdv_digit0", 32'(o_Segments), 32'h00);
        check("wrapdv_dp0", 32'(o_DP), 32'h0);
        run_until_anode(4'b1101, 20);
        check("wrapdv_digit1", 32'(o_Segments), 32'h78);

        // Reset during digit 2's lit period
        run_until_anode(4'b1011, 40);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_anode", 32'(o_Anode), 32'h0000000F);
        check("midrst_seg", 32'(o_Segments), 32'h0000007F);
        check("midrst_dp", 32'(o_DP), 32'h1);
        check("midrst_frame", 32'(o_Frame), 32'h0);
        rst = 1'b0;
        run_until_anode(4'b1110, 20);
        check("postrst_digit0", 32'(o_Segments), 32'h40);

        // Random phase
        for (int i = 0; i < 1500; i++) begin
            dv    = ($urandom_range(0, 7) == 0);
            bcd   = 16'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 49) == 0) bl = ~bl;
            rst   = ($urandom_range(0, 399) == 0);
            tick();
        end
        dv = 1'b0;
        rst = 1'b0;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
